instr_mem_loader: RTL and testbench

Writer-side companion to the instruction memory: loads a program into the 32-word instruction store at run time instead of relying on a file preload. It accepts a byte stream over a valid/ready handshake, assembles 32-bit instructions MSB-first, and issues word writes on the memory write port. It holds the CPU in reset while a load is in progress.

---
 rtl/instr_mem_loader.sv | 137 +++++++++++++
 tb/tb_instr_mem_loader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Run-time loader for the instruction store: assembles MSB-first bytes into 32-bit words and writes them.
// Optional LOADER_CLEAR_EN: zero every word before receiving the program.
module instr_mem_loader #(
    parameter int WORDS  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_addr_o,
    output logic [31:0]       mem_data_o,
    output logic              busy_o,
    output logic              cpu_hold_o,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
`ifdef LOADER_CLEAR_EN
        CLEAR = 3'd1,
`endif
        RECV  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] WORDS_L = (ADDR_W + 1)'(WORDS);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W + 1)'(1);

    state_t          state_q, state_d;
    logic [ADDR_W:0] len_q, len_d;
    logic [ADDR_W:0] idx_q, idx_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [31:0]     acc_q, acc_d;
    logic            err_q, err_d;
    logic [31:0]     word_addr;

    assign word_addr  = {{(32 - ADDR_W - 2){1'b0}}, idx_q[ADDR_W-1:0], 2'b00};
    assign busy_o     = (state_q != IDLE);
    assign cpu_hold_o = busy_o;
    assign err_o      = err_q;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        err_d        = err_q;
        byte_ready_o = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        done_o       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_i != '0 && len_i <= WORDS_L) begin
                        len_d = len_i;
                        idx_d = '0;
                        cnt_d = '0;
                        acc_d = '0;
                        err_d = 1'b0;
`ifdef LOADER_CLEAR_EN
                        state_d = CLEAR;
`else
                        state_d = RECV;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
`ifdef LOADER_CLEAR_EN
            CLEAR: begin
                mem_we_o   = 1'b1;
                mem_addr_o = word_addr;
                if (idx_q == WORDS_L - ONE) begin
                    idx_d   = '0;
                    state_d = RECV;
                end else begin
                    idx_d = idx_q + ONE;
                end
            end
`endif
            RECV: begin
                byte_ready_o = 1'b1;
                if (byte_valid_i) begin
                    acc_d = {acc_q[23:0], byte_i};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                mem_we_o   = 1'b1;
                mem_addr_o = word_addr;
                mem_data_o = acc_q;
                idx_d      = idx_q + ONE;
                cnt_d      = '0;
                state_d    = (idx_q == len_q - ONE) ? DONE : RECV;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected writes are queued at start, a monitor checks each write.
module tb_instr_mem_loader;

    localparam int WORDS  = 32;
    localparam int ADDR_W = 5;
`ifdef LOADER_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_i;
    logic              start_i;
    logic [ADDR_W:0]   len_i;
    logic [7:0]        byte_i;
    logic              byte_valid_i;
    logic              byte_ready_o;
    logic              mem_we_o;
    logic [31:0]       mem_addr_o;
    logic [31:0]       mem_data_o;
    logic              busy_o;
    logic              cpu_hold_o;
    logic              done_o;
    logic              err_o;

    instr_mem_loader #(.WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .len_i        (len_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .busy_o       (busy_o),
        .cpu_hold_o   (cpu_hold_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          need;
    } wr_t;

    wr_t         exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          bytes_sent = 0;
    int          wr_cnt = 0;
    logic [31:0] act_mem[WORDS];
    logic [31:0] exp_mem[WORDS];
    logic [31:0] words[WORDS];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        wr_t e;
        if (mem_we_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", mem_addr_o, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", mem_addr_o, e.addr);
                check("write_data", mem_data_o, e.data);
                if (e.need >= 0) begin
                    wr_cnt++;
                    check("bytes_before_write", bytes_sent, e.need);
                end
            end
            act_mem[mem_addr_o[ADDR_W+1:2]] = mem_data_o;
        end
        if (done_o) begin
            check("done_with_writes_pending", exp_q.size(), 0);
        end
    end

    task automatic push_load(input int len);
        wr_t e;
        if (CLR) begin
            for (int i = 0; i < WORDS; i++) begin
                e.addr = 32'(i * 4); e.data = '0; e.need = -1;
                exp_q.push_back(e);
                exp_mem[i] = '0;
            end
        end
        for (int i = 0; i < len; i++) begin
            e.addr = 32'(i * 4); e.data = words[i]; e.need = 4 * (i + 1);
            exp_q.push_back(e);
            exp_mem[i] = words[i];
        end
    endtask

    task automatic drive_bytes(input int nbytes, input bit tog);
        int k = 0;
        int budget = 0;
        bit phase = 1'b1;
        bit acc;
        while (k < nbytes && budget < 4000) begin
            @(negedge clk);
            byte_valid_i = tog ? phase : 1'b1;
            phase = ~phase;
            byte_i = words[k / 4][31 - 8 * (k % 4) -: 8];
            acc = byte_valid_i && byte_ready_o;
            @(posedge clk);
            if (acc) begin
                k++;
                bytes_sent++;
            end
            budget++;
        end
        if (k < nbytes) check("byte_drive_timeout", k, nbytes);
        @(negedge clk);
        byte_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int exp_cycles, input string nm);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
            if (c == 1) check({nm, "_busy_after_start"}, busy_o, 1);
        end while (!done_o && c < 5000);
        check({nm, "_done_seen"}, done_o, 1);
        if (exp_cycles > 0) check({nm, "_cycles_to_done"}, c, exp_cycles);
        check({nm, "_hold_during_done"}, cpu_hold_o, 1);
        @(negedge clk);
        check({nm, "_done_one_cycle"}, done_o, 0);
        check({nm, "_busy_falls"}, busy_o, 0);
        check({nm, "_hold_falls"}, cpu_hold_o, 0);
    endtask

    task automatic run_load(input int len, input bit tog, input bit pulse, input string nm);
        bytes_sent = 0;
        wr_cnt = 0;
        push_load(len);
        @(negedge clk);
        start_i = 1'b1;
        len_i = (ADDR_W + 1)'(len);
        @(posedge clk);
        fork
            drive_bytes(4 * len, tog);
            wait_done(tog ? -1 : 1 + 5 * len + (CLR ? WORDS : 0), nm);
            begin
                @(negedge clk);
                start_i = 1'b0;
                check({nm, "_err_cleared"}, err_o, 0);
                if (pulse) begin
                    repeat (20) @(negedge clk);
                    start_i = 1'b1;
                    len_i = (ADDR_W + 1)'(1);
                    @(negedge clk);
                    start_i = 1'b0;
                    check({nm, "_busy_after_pulse"}, busy_o, 1);
                end
            end
        join
        check({nm, "_queue_drained"}, exp_q.size(), 0);
        check({nm, "_word_writes"}, wr_cnt, len);
    endtask

    task automatic bad_start(input int len, input string nm);
        @(negedge clk);
        start_i = 1'b1;
        len_i = (ADDR_W + 1)'(len);
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        check({nm, "_err_set"}, err_o, 1);
        check({nm, "_busy_idle"}, busy_o, 0);
        @(negedge clk);
        check({nm, "_still_idle"}, busy_o, 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            act_mem[i] = '0;
            exp_mem[i] = '0;
            words[i]   = '0;
        end
        rst_i = 1'b0;
        start_i = 1'b0;
        len_i = '0;
        byte_i = '0;
        byte_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", byte_ready_o, 0);
        check("rst_we", mem_we_o, 0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_data", mem_data_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_hold", cpu_hold_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        rst_i = 1'b1;

        // Bytes 20 01 00 0A 8C 22 00 04, MSB first
        words[0] = 32'h2001_000A;
        words[1] = 32'h8C22_0004;
        run_load(2, 1'b0, 1'b0, "two_words");

        words[0] = 32'hDEAD_BEEF;
        run_load(1, 1'b0, 1'b0, "single_word");
        for (int i = 0; i < WORDS; i++) check("readback", act_mem[i], exp_mem[i]);

        words[0] = 32'h1234_5678;
        run_load(1, 1'b1, 1'b0, "valid_toggle");

        bad_start(0, "len_zero");
        bad_start(33, "len_33");
        words[0] = 32'hCAFE_F00D;
        run_load(1, 1'b0, 1'b0, "after_err");

        // Reset two bytes into word 1: only word 0 may be written
        words[0] = 32'h0BAD_F00D;
        words[1] = 32'h5566_7788;
        bytes_sent = 0;
        push_load(1);
        @(negedge clk);
        start_i = 1'b1;
        len_i = (ADDR_W + 1)'(2);
        @(posedge clk);
        #1 start_i = 1'b0;
        drive_bytes(6, 1'b0);
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        check("midrst_ready", byte_ready_o, 0);
        check("midrst_we", mem_we_o, 0);
        check("midrst_addr", mem_addr_o, 0);
        check("midrst_data", mem_data_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_hold", cpu_hold_o, 0);
        check("midrst_done", done_o, 0);
        check("midrst_err", err_o, 0);
        check("midrst_queue", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        words[0] = 32'hA1B2_C3D4;
        run_load(1, 1'b0, 1'b0, "after_reset");
        check("midrst_word1_unwritten", act_mem[1], exp_mem[1]);

        for (int i = 0; i < WORDS; i++) begin
            words[i] = {8'(i), 8'hA5, 8'(8'hFF - 8'(i)), 8'h3C};
        end
        run_load(32, 1'b0, 1'b1, "full_load");
        for (int i = 0; i < WORDS; i++) check("full_readback", act_mem[i], exp_mem[i]);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
